// File: rtl/ysyx_23060240_lsu_pkg.sv
// Shared encodings for the load/store unit: decoder ctrl codes, FSM states,
// AXI response/size constants and the access-size / alignment helpers.
package ysyx_23060240_lsu_pkg;

  localparam logic [2:0] RD_LB  = 3'b001;
  localparam logic [2:0] RD_LBU = 3'b010;
  localparam logic [2:0] RD_LH  = 3'b011;
  localparam logic [2:0] RD_LHU = 3'b100;
  localparam logic [2:0] RD_LW  = 3'b101;

  localparam logic [7:0] WR_SB = 8'h01;
  localparam logic [7:0] WR_SH = 8'h02;
  localparam logic [7:0] WR_SW = 8'h03;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WREQ,
    ST_WRESP,
    ST_DONE
  } lsu_state_e;

  function automatic logic [2:0] access_size(input logic       is_load,
                                             input logic [2:0] rd_ctrl,
                                             input logic [7:0] wr_ctrl);
    logic [2:0] sz;
    sz = SIZE_B;
    if (is_load) begin
      case (rd_ctrl)
        RD_LH, RD_LHU: sz = SIZE_H;
        RD_LW:         sz = SIZE_W;
        default:       sz = SIZE_B;
      endcase
    end else begin
      case (wr_ctrl)
        WR_SH:   sz = SIZE_H;
        WR_SW:   sz = SIZE_W;
        default: sz = SIZE_B;
      endcase
    end
    return sz;
  endfunction

  function automatic logic misaligned(input logic       is_load,
                                      input logic [2:0] rd_ctrl,
                                      input logic [7:0] wr_ctrl,
                                      input logic [1:0] addr_lo);
    logic [2:0] sz;
    sz = access_size(is_load, rd_ctrl, wr_ctrl);
    return ((sz == SIZE_H) && addr_lo[0]) || ((sz == SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060240_lsu_align.sv
// Byte-lane steering: shifts store data/strobes into place and extracts
// sign/zero-extended load results from the returned bus word.
module ysyx_23060240_lsu_align
  import ysyx_23060240_lsu_pkg::*;
(
  input  logic [2:0]  rd_ctrl,
  input  logic [7:0]  wr_ctrl,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ld_data
);

  logic [4:0]  lane_sh;
  logic [31:0] rshift;

  assign lane_sh = {addr_lo, 3'b000};

  always_comb begin
    wdata   = st_data << lane_sh;
    rshift  = rdata >> lane_sh;
    wstrb   = 4'b0000;
    ld_data = '0;
    case (wr_ctrl)
      WR_SB:   wstrb = 4'b0001 << addr_lo;
      WR_SH:   wstrb = 4'b0011 << addr_lo;
      WR_SW:   wstrb = 4'b1111;
      default: wstrb = 4'b0000;
    endcase
    case (rd_ctrl)
      RD_LB:   ld_data = {{24{rshift[7]}}, rshift[7:0]};
      RD_LBU:  ld_data = {24'd0, rshift[7:0]};
      RD_LH:   ld_data = {{16{rshift[15]}}, rshift[15:0]};
      RD_LHU:  ld_data = {16'd0, rshift[15:0]};
      RD_LW:   ld_data = rshift;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060240_lsu.sv
// Load/store unit: one outstanding AXI4-Lite access per EXU request.
// Optional alignment trap enabled by defining LSU_MISALIGN_CHECK_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | ready_out high, waiting for valid_in
// ST_RADDR | arvalid held until arready
// ST_RDATA | rready held until rvalid; result captured
// ST_WREQ  | awvalid/wvalid each held until its own handshake
// ST_WRESP | bready held until bvalid
// ST_DONE  | valid_out pulse (no-bus requests spend one extra cycle here)
module ysyx_23060240_lsu
  import ysyx_23060240_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic            mem_rd_en,
  input  logic            mem_wr_en,
  input  logic [2:0]      rd_ctrl,
  input  logic [7:0]      wr_ctrl,
  input  logic [2:0]      arsize_in,
  input  logic [2:0]      awsize_in,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] st_data,
  output logic            valid_out,
  output logic [XLEN-1:0] ld_data,
  output logic            err_out,
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  output logic [2:0]      arsize,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  output logic [XLEN-1:0] awaddr,
  output logic            awvalid,
  input  logic            awready,
  output logic [2:0]      awsize,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      wstrb,
  output logic            wvalid,
  input  logic            wready,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  lsu_state_e  state;
  logic [2:0]  rd_ctrl_q;
  logic        done_pend;
  logic        done_err;
  logic        mis;
  logic        aw_pend;
  logic        w_pend;
  logic [1:0]  lane;
  logic [31:0] al_wdata;
  logic [3:0]  al_wstrb;
  logic [31:0] al_ld;

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis = (mem_rd_en || mem_wr_en) && misaligned(mem_rd_en, rd_ctrl, wr_ctrl, addr[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign ready_out = (state == ST_IDLE);
  assign aw_pend   = awvalid && !awready;
  assign w_pend    = wvalid && !wready;
  // Store lanes come from the live request at accept; loads use the latched address.
  assign lane      = (state == ST_IDLE) ? addr[1:0] : araddr[1:0];

  ysyx_23060240_lsu_align u_align (
    .rd_ctrl (rd_ctrl_q),
    .wr_ctrl (wr_ctrl),
    .addr_lo (lane),
    .st_data (st_data),
    .rdata   (rdata),
    .wdata   (al_wdata),
    .wstrb   (al_wstrb),
    .ld_data (al_ld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rd_ctrl_q <= '0;
      done_pend <= 1'b0;
      done_err  <= 1'b0;
      valid_out <= 1'b0;
      ld_data   <= '0;
      err_out   <= 1'b0;
      araddr    <= '0;
      arvalid   <= 1'b0;
      arsize    <= '0;
      rready    <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      awsize    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (valid_in) begin
            rd_ctrl_q <= rd_ctrl;
            if (mis || (!mem_rd_en && !mem_wr_en)) begin
              state     <= ST_DONE;
              done_pend <= 1'b1;
              done_err  <= mis;
            end else if (mem_rd_en) begin
              state   <= ST_RADDR;
              arvalid <= 1'b1;
              araddr  <= addr;
              arsize  <= arsize_in;
            end else begin
              state   <= ST_WREQ;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              awaddr  <= addr;
              awsize  <= awsize_in;
              wdata   <= al_wdata;
              wstrb   <= al_wstrb;
            end
          end
        end
        ST_RADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            err_out   <= (rresp != RESP_OKAY);
            ld_data   <= (rresp != RESP_OKAY) ? '0 : al_ld;
            valid_out <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_WREQ: begin
          awvalid <= aw_pend;
          wvalid  <= w_pend;
          if (!aw_pend && !w_pend) begin
            bready <= 1'b1;
            state  <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            err_out   <= (bresp != RESP_OKAY);
            ld_data   <= '0;
            valid_out <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (done_pend) begin
            done_pend <= 1'b0;
            valid_out <= 1'b1;
            err_out   <= done_err;
            ld_data   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_lsu.sv
// Scoreboard bench for ysyx_23060240_lsu: directed cases plus randomized
// traffic against a queue-based reference model and a delay-configurable AXI slave.
module tb_ysyx_23060240_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0, ready_out;
  logic        mem_rd_en = 1'b0, mem_wr_en = 1'b0;
  logic [2:0]  rd_ctrl = '0;
  logic [7:0]  wr_ctrl = '0;
  logic [2:0]  arsize_in = '0, awsize_in = '0;
  logic [31:0] addr = '0, st_data = '0;
  logic        valid_out, err_out;
  logic [31:0] ld_data;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [2:0]  arsize, awsize;
  logic [3:0]  wstrb;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  always #5 clk = ~clk;

  ysyx_23060240_lsu dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .rd_ctrl(rd_ctrl), .wr_ctrl(wr_ctrl),
    .arsize_in(arsize_in), .awsize_in(awsize_in), .addr(addr), .st_data(st_data),
    .valid_out(valid_out), .ld_data(ld_data), .err_out(err_out),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arsize(arsize),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awsize(awsize),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct { logic [31:0] ld; logic err; bit is_store; int lat; } comp_t;
  typedef struct { logic [31:0] addr; logic [2:0] size; logic [31:0] rdata; logic [1:0] resp; } rd_t;
  typedef struct { logic [31:0] addr; logic [2:0] size; logic [31:0] wdata; logic [3:0] wstrb; logic [1:0] resp; } wr_t;

  comp_t comp_q[$];
  rd_t   rd_q[$];
  wr_t   wr_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, accept_cyc = 0, done_cnt = 0;
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  int aw_hi = 0, w_hi = 0, vo_hi = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int d);
    return (d >= 0) ? d : int'($urandom_range(0, 3));
  endfunction

  // Reference model: byte counts, alignment and lane extraction from the rules.
  function automatic int ld_bytes(input logic [2:0] rc);
    return (rc == 3'd3 || rc == 3'd4) ? 2 : (rc == 3'd5) ? 4 : 1;
  endfunction

  function automatic int st_bytes(input logic [7:0] wc);
    return (wc == 8'h02) ? 2 : (wc == 8'h03) ? 4 : 1;
  endfunction

  function automatic logic [2:0] size_of(input int nb);
    return (nb == 1) ? 3'd0 : (nb == 2) ? 3'd1 : 3'd2;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] rc, input logic [31:0] d, input int off);
    logic [31:0] b;
    b = d >> (8 * off);
    case (rc)
      3'd1:    return 32'(int'($signed(b[7:0])));
      3'd2:    return 32'(b[7:0]);
      3'd3:    return 32'(int'($signed(b[15:0])));
      3'd4:    return 32'(b[15:0]);
      default: return b;
    endcase
  endfunction

  task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] rc, input logic [7:0] wc,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                       input logic [1:0] resp, input int lat, input bit wait_done);
    comp_t c;
    rd_t   r;
    wr_t   w;
    int    t, target, nb, off;
    bit    mis;
    nb  = rd_en ? ld_bytes(rc) : st_bytes(wc);
    off = int'(a[1:0]);
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if (rd_en || wr_en) mis = (off % nb) != 0;
`endif
    mem_rd_en = rd_en; mem_wr_en = wr_en; rd_ctrl = rc; wr_ctrl = wc;
    arsize_in = size_of(ld_bytes(rc)); awsize_in = size_of(st_bytes(wc));
    addr = a; st_data = sd; valid_in = 1'b1;
    t = 0;
    while (!ready_out && t < 50) begin @(negedge clk); t++; end
    check("accept_ready", ready_out, 1'b1);
    accept_cyc = cyc;
    target = done_cnt + 1;
    c.ld = '0; c.err = 1'b0; c.is_store = 1'b0; c.lat = 2;
    if (mis) c.err = 1'b1;
    else if (rd_en) begin
      r.addr = a; r.size = size_of(nb); r.rdata = rdat; r.resp = resp;
      rd_q.push_back(r);
      c.err = (resp != 2'b00);
      c.ld  = c.err ? 32'd0 : load_val(rc, rdat, off);
      c.lat = lat;
    end else if (wr_en) begin
      w.addr = a; w.size = size_of(nb); w.resp = resp;
      w.wdata = sd << (8 * off);
      w.wstrb = (nb == 4) ? 4'hF : 4'(((1 << nb) - 1) << off);
      wr_q.push_back(w);
      c.err = (resp != 2'b00); c.is_store = 1'b1; c.lat = lat;
    end
    comp_q.push_back(c);
    @(negedge clk);
    valid_in = 1'b0;
    mem_rd_en = 1'($urandom); mem_wr_en = 1'($urandom); rd_ctrl = 3'($urandom); wr_ctrl = 8'($urandom);
    addr = $urandom; st_data = $urandom;
    if (wait_done) begin
      t = 0;
      while (done_cnt < target && t < 300) begin @(negedge clk); t++; end
      check("completion", done_cnt >= target, 1'b1);
    end
  endtask

  // AXI slave with per-channel delays (-1 = random) and protocol checks.
  int  ar_cnt = -1, r_cnt = 0, aw_cnt = -1, w_cnt = -1, b_cnt = -1;
  bit  r_pend = 0, aw_hs = 0, w_hs = 0, ar_wait = 0, aw_wait = 0, w_wait = 0;
  rd_t cur_rd;

  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        ar_cnt = -1; aw_cnt = -1; w_cnt = -1; b_cnt = -1;
        r_pend = 0; aw_hs = 0; w_hs = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
      end else begin
        if (ar_wait) check("arvalid_held", arvalid, 1'b1);
        if (aw_wait) check("awvalid_held", awvalid, 1'b1);
        if (w_wait)  check("wvalid_held", wvalid, 1'b1);
        if (bready)  check("bready_after_aw_w", {awvalid, wvalid}, 0);
        if (awvalid) aw_hi++;
        if (wvalid)  w_hi++;
        if (!arvalid) begin arready = 0; ar_cnt = -1; end
        else begin
          if (ar_cnt < 0) ar_cnt = pick(ar_delay);
          if (ar_cnt == 0) begin
            arready = 1; ar_cnt = -1;
            check("ar_expected", rd_q.size() != 0, 1'b1);
            if (rd_q.size() != 0) begin
              cur_rd = rd_q.pop_front();
              check("araddr", araddr, cur_rd.addr);
              check("arsize", arsize, cur_rd.size);
              r_pend = 1; r_cnt = pick(r_delay);
            end
          end else begin arready = 0; ar_cnt--; end
        end
        ar_wait = arvalid && !arready;
        if (rvalid) begin rvalid = 0; rdata = $urandom; rresp = 2'($urandom); end
        else if (r_pend && rready) begin
          if (r_cnt == 0) begin
            rvalid = 1; rdata = cur_rd.rdata; rresp = cur_rd.resp; r_pend = 0;
          end else r_cnt--;
        end
        if (!awvalid) begin awready = 0; aw_cnt = -1; end
        else begin
          if (aw_cnt < 0) aw_cnt = pick(aw_delay);
          if (aw_cnt == 0) begin
            awready = 1; aw_cnt = -1; aw_hs = 1;
            check("aw_expected", wr_q.size() != 0, 1'b1);
            if (wr_q.size() != 0) begin
              check("awaddr", awaddr, wr_q[0].addr);
              check("awsize", awsize, wr_q[0].size);
            end
          end else begin awready = 0; aw_cnt--; end
        end
        aw_wait = awvalid && !awready;
        if (!wvalid) begin wready = 0; w_cnt = -1; end
        else begin
          if (w_cnt < 0) w_cnt = pick(w_delay);
          if (w_cnt == 0) begin
            wready = 1; w_cnt = -1; w_hs = 1;
            check("w_expected", wr_q.size() != 0, 1'b1);
            if (wr_q.size() != 0) begin
              check("wdata", wdata, wr_q[0].wdata);
              check("wstrb", wstrb, wr_q[0].wstrb);
            end
          end else begin wready = 0; w_cnt--; end
        end
        w_wait = wvalid && !wready;
        if (bvalid) bvalid = 0;
        else if (bready) begin
          check("bready_after_handshakes", aw_hs && w_hs, 1'b1);
          if (b_cnt < 0) b_cnt = pick(b_delay);
          if (b_cnt == 0) begin
            bvalid = 1; b_cnt = -1; aw_hs = 0; w_hs = 0;
            bresp = (wr_q.size() != 0) ? wr_q[0].resp : 2'b00;
            if (wr_q.size() != 0) void'(wr_q.pop_front());
          end else b_cnt--;
        end
      end
    end
  end

  // Completion monitor
  bit    prev_vo = 0;
  comp_t e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) prev_vo = 0;
      else begin
        if (valid_out) begin
          vo_hi++;
          check("ready_out_busy", ready_out, 1'b0);
          if (prev_vo) check("valid_out_single_cycle", prev_vo, 1'b0);
          else begin
            check("completion_expected", comp_q.size() != 0, 1'b1);
            if (comp_q.size() != 0) begin
              e = comp_q.pop_front();
              check("err_out", err_out, e.err);
              if (!e.is_store) check("ld_data", ld_data, e.ld);
              if (e.lat >= 0) check("latency", cyc - accept_cyc, e.lat);
            end
            done_cnt++;
          end
        end
        prev_vo = valid_out;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  logic [31:0] mis_err_exp;
  int          t;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_out", ready_out, 1'b1);
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_err_out", err_out, 1'b0);
    check("rst_axi_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);

    issue(1, 0, 3'd1, 8'h00, 32'h8000_0003, 32'h0, 32'h8000_0000, 2'b00, 3, 1);
    check("lb_result", ld_data, 32'hFFFF_FF80);
    issue(1, 0, 3'd2, 8'h00, 32'h8000_0003, 32'h0, 32'h8000_0000, 2'b00, 3, 1);
    check("lbu_result", ld_data, 32'h0000_0080);

    issue(0, 1, 3'd0, 8'h02, 32'h8000_0002, 32'h0000_1234, 32'h0, 2'b00, 3, 1);
    check("sh_err", err_out, 1'b0);

    aw_delay = 3; aw_hi = 0; w_hi = 0; vo_hi = 0;
    issue(0, 1, 3'd0, 8'h03, 32'h8000_0040, 32'hCAFE_F00D, 32'h0, 2'b00, 6, 1);
    repeat (3) @(negedge clk);
    check("sw_awvalid_cycles", aw_hi, 4);
    check("sw_wvalid_cycles", w_hi, 1);
    check("sw_valid_out_pulses", vo_hi, 1);
    aw_delay = 0;

    issue(1, 0, 3'd5, 8'h00, 32'h8000_0008, 32'h0, 32'hDEAD_BEEF, 2'b10, 3, 1);
    check("lw_slverr_err", err_out, 1'b1);
    check("lw_slverr_ld", ld_data, 32'd0);
    issue(1, 0, 3'd5, 8'h00, 32'h8000_000C, 32'h0, 32'h0BAD_F00D, 2'b00, 3, 1);
    check("lw_after_err", ld_data, 32'h0BAD_F00D);

    r_delay = 1000;
    issue(1, 0, 3'd5, 8'h00, 32'h8000_0020, 32'h0, 32'h5555_AAAA, 2'b00, -1, 0);
    t = 0;
    while (!rready && t < 50) begin @(negedge clk); t++; end
    check("reached_rdata", rready, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_axi_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    check("midrst_outputs", {valid_out, err_out}, 0);
    check("midrst_ld_data", ld_data, 32'd0);
    rd_q.delete(); wr_q.delete(); comp_q.delete();
    r_delay = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_ready_out", ready_out, 1'b1);
    @(negedge clk);
    issue(1, 0, 3'd5, 8'h00, 32'h8000_0010, 32'h0, 32'h1122_3344, 2'b00, 3, 1);
    check("postrst_lw", ld_data, 32'h1122_3344);

`ifdef LSU_MISALIGN_CHECK_EN
    mis_err_exp = 32'd1;
`else
    mis_err_exp = 32'd0;
`endif
    issue(1, 0, 3'd5, 8'h00, 32'h8000_0002, 32'h0, 32'h7788_99AA, 2'b00, 3, 1);
    check("misaligned_lw_err", err_out, mis_err_exp);

    ar_delay = -1; r_delay = -1; aw_delay = -1; w_delay = -1; b_delay = -1;
    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 9) < 5),
            3'($urandom_range(1, 5)), 8'($urandom_range(1, 3)),
            32'h8000_0000 | ($urandom & 32'h0000_FFFF), $urandom, $urandom,
            ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, -1, 1);
    end

    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 9) < 6),
            3'($urandom_range(1, 5)), 8'($urandom_range(1, 3)),
            32'h8000_0000 | ($urandom & 32'h0000_0FFF), $urandom, $urandom,
            ($urandom_range(0, 5) == 0) ? 2'b11 : 2'b00, 3, 1);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", comp_q.size() + rd_q.size() + wr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
